// File: rtl/proc_core.sv
// proc_core -- small multi-cycle register-machine core with a mux-based bus.
//
// Each instruction is fetched from D in T0 and executed over T1..T3:
//   LOAD  (0) : T1 waits for D_VALID, then Rx <- D
//   MOV   (1) : T1 Rx <- Ry
//   ADD..XOR (2..6) : T1 A <- Rx, T2 G <- A op Ry, T3 Rx <- G
//   NOT   (7) : T1 Rx <- ~Ry
//   8..15     : NOP, finishes in T1
// Instruction layout: opcode in the top 4 bits, then Rx, then Ry
// (RB = log2(NREGS) bits each); remaining low bits are ignored.
//
// Optional feature macro: PROC_CORE_FLAGS_EN
//   defined   : ZF/CF registers, updated at each ALU-op write-back
//   undefined : ZF and CF tied to 0, no flag state
//
// Ports:
//   CLKb      in   1      clock, rising edge
//   CLR       in   1      synchronous active-high reset, highest priority
//   D         in   WIDTH  instruction or immediate word
//   D_VALID   in   1      D is valid this cycle
//   READY     out  1      core accepts an instruction (T0 only)
//   PEEK_ADDR in   RB     register index for REG_PEEK
//   REG_PEEK  out  WIDTH  combinational read of register[PEEK_ADDR]
//   BUS       out  WIDTH  internal bus value, 0 when undriven
//   TIMESTEP  out  2      current step T0..T3
//   DONE      out  1      final step of the current instruction
//   ZF        out  1      zero flag
//   CF        out  1      carry / borrow flag
module proc_core #(
  parameter int WIDTH = 10,
  parameter int NREGS = 4,
  localparam int RB = $clog2(NREGS)
) (
  input  logic             CLKb,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             READY,
  input  logic [RB-1:0]    PEEK_ADDR,
  output logic [WIDTH-1:0] REG_PEEK,
  output logic [WIDTH-1:0] BUS,
  output logic [1:0]       TIMESTEP,
  output logic             DONE,
  output logic             ZF,
  output logic             CF
);

  // Only the decoded fields of the instruction are kept.
  localparam int IW = 4 + 2 * RB;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  step_t            step;
  step_t            step_next;
  logic [WIDTH-1:0] regs [NREGS];
  logic [IW-1:0]    ir;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] g;
  logic [3:0]       opcode;
  logic [RB-1:0]    rx;
  logic [RB-1:0]    ry;

  logic [WIDTH-1:0] bus;
  logic             ready;
  logic             done;
  logic             ir_load;
  logic             a_load;
  logic             g_load;
  logic             reg_we;
  logic [WIDTH-1:0] reg_wdata;
  logic [WIDTH-1:0] alu_res;

  assign opcode = ir[IW-1 -: 4];
  assign rx     = ir[IW-5 -: RB];
  assign ry     = ir[IW-5-RB -: RB];

  // Step sequencing, bus source selection and write controls.
  always_comb begin
    step_next = step;
    bus       = '0;
    ready     = 1'b0;
    done      = 1'b0;
    ir_load   = 1'b0;
    a_load    = 1'b0;
    g_load    = 1'b0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    if (CLR) begin
      // Abandon anything in flight: no bus, no DONE, no write-back.
      step_next = T0;
    end else begin
      case (step)
        T0: begin
          ready = 1'b1;
          if (D_VALID) begin
            bus       = D;
            ir_load   = 1'b1;
            step_next = T1;
          end else begin
            step_next = T0;
          end
        end
        T1: begin
          case (opcode)
            OP_LOAD: begin
              if (D_VALID) begin
                bus       = D;
                reg_we    = 1'b1;
                reg_wdata = D;
                done      = 1'b1;
                step_next = T0;
              end else begin
                step_next = T1;
              end
            end
            OP_MOV: begin
              bus       = regs[ry];
              reg_we    = 1'b1;
              reg_wdata = regs[ry];
              done      = 1'b1;
              step_next = T0;
            end
            OP_NOT: begin
              bus       = regs[ry];
              reg_we    = 1'b1;
              reg_wdata = ~regs[ry];
              done      = 1'b1;
              step_next = T0;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              bus       = regs[rx];
              a_load    = 1'b1;
              step_next = T2;
            end
            default: begin
              // NOP: finish immediately, nothing written.
              done      = 1'b1;
              step_next = T0;
            end
          endcase
        end
        T2: begin
          bus       = regs[ry];
          g_load    = 1'b1;
          step_next = T3;
        end
        T3: begin
          bus       = g;
          reg_we    = 1'b1;
          reg_wdata = g;
          done      = 1'b1;
          step_next = T0;
        end
        default: begin
          step_next = T0;
        end
      endcase
    end
  end

  // ALU: A combined with the bus (carrying Ry during T2).
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = a + bus;
      OP_SUB:  alu_res = a - bus;
      OP_AND:  alu_res = a & bus;
      OP_OR:   alu_res = a | bus;
      OP_XOR:  alu_res = a ^ bus;
      default: alu_res = '0;
    endcase
  end

  // Step register, instruction/operand registers and register file.
  always_ff @(posedge CLKb) begin
    if (CLR) begin
      step <= T0;
      ir   <= '0;
      a    <= '0;
      g    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      step <= step_next;
      if (ir_load) begin
        ir <= D[WIDTH-1 -: IW];
      end
      if (a_load) begin
        a <= bus;
      end
      if (g_load) begin
        g <= alu_res;
      end
      if (reg_we) begin
        regs[rx] <= reg_wdata;
      end
    end
  end

`ifdef PROC_CORE_FLAGS_EN
  logic zf_q;
  logic cf_q;
  logic g_carry;
  logic alu_carry;

  // Carry-out of A+B is set exactly when B exceeds ~A; borrow when A < B.
  always_comb begin
    alu_carry = 1'b0;
    case (opcode)
      OP_ADD:  alu_carry = (bus > ~a);
      OP_SUB:  alu_carry = (a < bus);
      default: alu_carry = 1'b0;
    endcase
  end

  // Flags: carry is captured with G, both flags commit at the T3 write-back.
  always_ff @(posedge CLKb) begin
    if (CLR) begin
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      g_carry <= 1'b0;
    end else begin
      if (g_load) begin
        g_carry <= alu_carry;
      end
      if (step == T3) begin
        zf_q <= (g == '0);
        cf_q <= g_carry;
      end
    end
  end

  assign ZF = zf_q;
  assign CF = cf_q;
`else
  assign ZF = 1'b0;
  assign CF = 1'b0;
`endif

  assign READY    = ready;
  assign DONE     = done;
  assign BUS      = bus;
  assign TIMESTEP = step;
  assign REG_PEEK = regs[PEEK_ADDR];

endmodule

// File: tb/tb_proc_core.sv
// Testbench for proc_core (WIDTH=10, NREGS=4): a table of per-cycle
// vectors followed by hand-written LOAD-stall and mid-instruction reset
// sequences. Flag expectations apply when PROC_CORE_FLAGS_EN is defined,
// otherwise ZF/CF are expected to stay 0.
module tb_proc_core;

`ifdef PROC_CORE_FLAGS_EN
  localparam logic FLAGS = 1'b1;
`else
  localparam logic FLAGS = 1'b0;
`endif

  logic       clk;
  logic       clr;
  logic [9:0] d;
  logic       d_valid;
  logic       ready;
  logic [1:0] peek_addr;
  logic [9:0] reg_peek;
  logic [9:0] bus;
  logic [1:0] timestep;
  logic       done;
  logic       zf;
  logic       cf;

  int n_checks = 0;
  int n_fail   = 0;

  proc_core #(.WIDTH(10), .NREGS(4)) dut (
    .CLKb      (clk),
    .CLR       (clr),
    .D         (d),
    .D_VALID   (d_valid),
    .READY     (ready),
    .PEEK_ADDR (peek_addr),
    .REG_PEEK  (reg_peek),
    .BUS       (bus),
    .TIMESTEP  (timestep),
    .DONE      (done),
    .ZF        (zf),
    .CF        (cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] d;
    logic       dv;
    logic [1:0] pa;
    logic [1:0] ts;
    logic       rdy;
    logic       dn;
    logic [9:0] bus;
    logic [9:0] peek;
    logic       zf;
    logic       cf;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs for the coming cycle and let combinational outputs settle.
  task automatic apply(input logic c, input logic [9:0] dd, input logic dv, input logic [1:0] pa);
    clr       = c;
    d         = dd;
    d_valid   = dv;
    peek_addr = pa;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_regs_zero(input string tag);
    for (int r = 0; r < 4; r++) begin
      peek_addr = r[1:0];
      #1;
      check($sformatf("%s R%0d", tag, r), {22'd0, reg_peek}, 32'h0);
    end
  endtask

  initial begin
    //            d       dv    pa    ts     rdy   dn    bus     peek    zf    cf
    vecs[0]  = '{10'h000, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0};
    vecs[1]  = '{10'h010, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 10'h010, 10'h000, 1'b0, 1'b0};
    vecs[2]  = '{10'h3FF, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1, 10'h3FF, 10'h000, 1'b0, 1'b0};
    vecs[3]  = '{10'h020, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 10'h020, 10'h3FF, 1'b0, 1'b0};
    vecs[4]  = '{10'h002, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1, 10'h002, 10'h000, 1'b0, 1'b0};
    vecs[5]  = '{10'h098, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 10'h098, 10'h002, 1'b0, 1'b0};
    vecs[6]  = '{10'h3A5, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0};
    vecs[7]  = '{10'h111, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 10'h002, 10'h3FF, 1'b0, 1'b0};
    vecs[8]  = '{10'h000, 1'b0, 2'd1, 2'd3, 1'b0, 1'b1, 10'h001, 10'h3FF, 1'b0, 1'b0};
    vecs[9]  = '{10'h000, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 10'h000, 10'h001, 1'b0, 1'b1};
    vecs[10] = '{10'h0C0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 10'h0C0, 10'h000, 1'b0, 1'b1};
    vecs[11] = '{10'h000, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1};
    vecs[12] = '{10'h000, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b1};
    vecs[13] = '{10'h000, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 10'h000, 10'h000, 1'b0, 1'b1};
    vecs[14] = '{10'h000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0};
    vecs[15] = '{10'h3C0, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 10'h3C0, 10'h001, 1'b1, 1'b0};
    vecs[16] = '{10'h2AA, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1, 10'h000, 10'h001, 1'b1, 1'b0};
    vecs[17] = '{10'h000, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 10'h000, 10'h001, 1'b1, 1'b0};
    vecs[18] = '{10'h074, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 10'h074, 10'h000, 1'b1, 1'b0};
    vecs[19] = '{10'h000, 1'b0, 2'd3, 2'd1, 1'b0, 1'b1, 10'h001, 10'h000, 1'b1, 1'b0};
    vecs[20] = '{10'h1EC, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 10'h1EC, 10'h001, 1'b1, 1'b0};
    vecs[21] = '{10'h000, 1'b0, 2'd2, 2'd1, 1'b0, 1'b1, 10'h001, 10'h002, 1'b1, 1'b0};
    vecs[22] = '{10'h000, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 10'h000, 10'h3FE, 1'b1, 1'b0};

    // Reset cycle: CLR wins over a valid word on D.
    apply(1'b1, 10'h155, 1'b1, 2'd0);
    check("clr ready", {31'd0, ready}, 32'd0);
    check("clr done",  {31'd0, done},  32'd0);
    check("clr bus",   {22'd0, bus},   32'h0);
    tick();
    apply(1'b0, 10'h000, 1'b0, 2'd0);
    check("rst ts",    {30'd0, timestep}, 32'd0);
    check("rst ready", {31'd0, ready},    32'd1);
    check("rst zf",    {31'd0, zf},       32'd0);
    check("rst cf",    {31'd0, cf},       32'd0);
    check_all_regs_zero("rst");

    // Table: LOAD/LOAD/ADD with carry, SUB to zero, NOP, MOV, NOT.
    for (int i = 0; i < 23; i++) begin
      apply(1'b0, vecs[i].d, vecs[i].dv, vecs[i].pa);
      check($sformatf("v%0d ts", i),    {30'd0, timestep}, {30'd0, vecs[i].ts});
      check($sformatf("v%0d ready", i), {31'd0, ready},    {31'd0, vecs[i].rdy});
      check($sformatf("v%0d done", i),  {31'd0, done},     {31'd0, vecs[i].dn});
      check($sformatf("v%0d bus", i),   {22'd0, bus},      {22'd0, vecs[i].bus});
      check($sformatf("v%0d peek", i),  {22'd0, reg_peek}, {22'd0, vecs[i].peek});
      check($sformatf("v%0d zf", i),    {31'd0, zf},       {31'd0, vecs[i].zf & FLAGS});
      check($sformatf("v%0d cf", i),    {31'd0, cf},       {31'd0, vecs[i].cf & FLAGS});
      tick();
    end

    // LOAD stall: three cycles without D_VALID keep T1 and leave R1 alone.
    apply(1'b0, 10'h010, 1'b1, 2'd1);
    check("stall fetch ts", {30'd0, timestep}, 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 10'h0F0, 1'b0, 2'd1);
      check($sformatf("stall%0d ts", k),   {30'd0, timestep}, 32'd1);
      check($sformatf("stall%0d done", k), {31'd0, done},     32'd0);
      check($sformatf("stall%0d R1", k),   {22'd0, reg_peek}, 32'h001);
      tick();
    end
    apply(1'b0, 10'h155, 1'b1, 2'd1);
    check("stall load done", {31'd0, done},     32'd1);
    check("stall load bus",  {22'd0, bus},      32'h155);
    check("stall load R1",   {22'd0, reg_peek}, 32'h001);
    tick();
    apply(1'b0, 10'h000, 1'b0, 2'd1);
    check("stall after ts", {30'd0, timestep}, 32'd0);
    check("stall after R1", {22'd0, reg_peek}, 32'h155);

    // Reset during T2 of ADD R1,R2: no DONE, no write-back.
    apply(1'b0, 10'h098, 1'b1, 2'd1);
    tick();
    apply(1'b0, 10'h000, 1'b0, 2'd1);
    check("midrst T1 ts",  {30'd0, timestep}, 32'd1);
    check("midrst T1 bus", {22'd0, bus},      32'h155);
    tick();
    apply(1'b1, 10'h000, 1'b0, 2'd1);
    check("midrst T2 ts",    {30'd0, timestep}, 32'd2);
    check("midrst T2 done",  {31'd0, done},     32'd0);
    check("midrst T2 ready", {31'd0, ready},    32'd0);
    check("midrst T2 bus",   {22'd0, bus},      32'h0);
    tick();
    apply(1'b0, 10'h000, 1'b0, 2'd1);
    check("midrst ts",    {30'd0, timestep}, 32'd0);
    check("midrst ready", {31'd0, ready},    32'd1);
    check("midrst done",  {31'd0, done},     32'd0);
    check("midrst zf",    {31'd0, zf},       32'd0);
    check("midrst cf",    {31'd0, cf},       32'd0);
    check_all_regs_zero("midrst");
    tick();
    check("midrst hold ts",   {30'd0, timestep}, 32'd0);
    check("midrst hold done", {31'd0, done},     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_core.md
PROC_CORE -- requirements
Module: proc_core

Interface
REQ-001 SHALL have parameter WIDTH, default 10, giving the data, instruction and register width; legal range 8..32.
REQ-002 SHALL have parameter NREGS, default 4, giving the register count; power of two, 2..16. RB = log2(NREGS); WIDTH >= 4+2*RB.
REQ-003 SHALL have port CLKb  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port CLR  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port D  in  WIDTH  external instruction or immediate word.
REQ-006 SHALL have port D_VALID  in  1  D holds a valid word this cycle.
REQ-007 SHALL have port READY  out  1  core accepts an instruction this cycle.
REQ-008 SHALL have port PEEK_ADDR  in  RB  register selected for REG_PEEK.
REQ-009 SHALL have port REG_PEEK  out  WIDTH  combinational read of register[PEEK_ADDR].
REQ-010 SHALL have port BUS  out  WIDTH  internal bus value this cycle; 0 when nothing drives it.
REQ-011 SHALL have port TIMESTEP  out  2  current step T0..T3.
REQ-012 SHALL have port DONE  out  1  high during the final step of an instruction.
REQ-013 SHALL have port ZF  out  1  zero flag.
REQ-014 SHALL have port CF  out  1  carry/borrow flag.

Function
REQ-015 SHALL use a mux-based internal bus and no tristate drivers; at most one source per cycle.
REQ-016 SHALL decode the instruction fields as: opcode = IR[WIDTH-1:WIDTH-4], Rx = the next RB bits below the opcode, Ry = the next RB bits below Rx; remaining low bits are ignored.
REQ-017 SHALL implement opcodes 0 LOAD, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT; opcodes 8-15 SHALL execute as NOP.
REQ-018 SHALL drive READY=1 only in T0 and never in a cycle with CLR=1; T0 with D_VALID=1 SHALL load IR from D and advance to T1. T0 with D_VALID=0 SHALL hold T0.
REQ-019 SHALL execute LOAD in T1 as: stall while D_VALID=0; when D_VALID=1, write Rx from D and assert DONE.
REQ-020 SHALL execute MOV in T1 as Rx <- Ry, and NOT in T1 as Rx <- ~Ry, each with DONE asserted.
REQ-021 SHALL execute ALU ops (2-6) as: T1 A <- Rx; T2 G <- A op Ry; T3 Rx <- G with DONE asserted.
REQ-022 SHALL treat a NOP as DONE in T1 with no register or flag change.
REQ-023 SHALL complete the write-back at the rising edge that ends the DONE cycle; TIMESTEP SHALL be 0 on the following cycle.
REQ-024 SHALL compute ADD/SUB modulo 2^WIDTH; ADD carry = carry-out; SUB C = 1 when Rx < Ry unsigned (borrow).
REQ-025 SHALL ignore D_VALID outside T0 and outside the LOAD T1 step.
REQ-026 SHALL make REG_PEEK reflect a register write on the cycle after that write.

Reset
REQ-027 SHALL, on CLKb rising with CLR=1, clear every register, IR, A, G, ZF and CF to 0 and set TIMESTEP to 0.
REQ-028 SHALL give CLR priority over every other event; an instruction in flight is abandoned with no write-back and no DONE.
REQ-029 SHALL hold READY=0, DONE=0 and BUS=0 in any cycle where CLR=1.

Configuration
REQ-030 SHALL, when PROC_CORE_FLAGS_EN is defined, update ZF (result==0) and CF at each ALU-op write-back; flags SHALL hold for every other instruction.
REQ-031 SHALL, without PROC_CORE_FLAGS_EN, tie ZF and CF to 0 and implement no flag registers.

Verification (WIDTH=10, NREGS=4, PROC_CORE_FLAGS_EN defined)
REQ-032 SHALL cover reset: CLR=1 for one cycle -> all REG_PEEK values 0x000, TIMESTEP=0, READY=1 on the next cycle.
REQ-033 SHALL cover add with carry: LOAD R1 (0x010) with imm 0x3FF, LOAD R2 (0x020) with imm 0x002, then ADD R1,R2 (0x098) -> DONE in T3, R1=0x001, CF=1, ZF=0.
REQ-034 SHALL cover the LOAD stall: after 0x010, hold D_VALID=0 for 3 cycles -> TIMESTEP stays 1, DONE=0, R1 unchanged; then D=0x155 with D_VALID=1 -> R1=0x155.
REQ-035 SHALL cover subtract to zero: SUB R0,R0 (0x0C0) -> R0=0x000, ZF=1, CF=0.
REQ-036 SHALL cover reset mid-operation: CLR=1 during T2 of ADD R1,R2 -> no DONE, TIMESTEP=0 next cycle, all registers 0.
REQ-037 SHALL cover an unused opcode: instruction 0x3C0 -> DONE in T1, registers and flags unchanged.
